// File: rtl/video_pkg.sv
// Shared register map, status/control bit positions and default 640x480 timing
// for the video scanout engine.
package video_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam int COORD_W = 10;

  typedef enum logic [3:0] {
    REG_CTRL        = 4'h0,
    REG_STATUS      = 4'h4,
    REG_LINE_CMP    = 4'h8,
    REG_FRAME_COUNT = 4'hC
  } reg_addr_e;

  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_PEND_LSB        = 4;
  localparam int STAT_ACTIVE_LSB      = 0;
  localparam int STAT_IN_VBLANK_BIT   = 8;
  localparam int STAT_VBLANK_PEND_BIT = 16;
  localparam int STAT_LINE_PEND_BIT   = 17;

  // Per-pixel control travelling alongside the framebuffer read latency.
  typedef struct packed {
    logic               hsync_n;
    logic               vsync_n;
    logic               blank_n;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pix_ctl_t;

  localparam pix_ctl_t PIX_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0,
                                    x: '0, y: '0};

  function automatic int frame_sel_w(input int num_frames);
    return (num_frames > 1) ? $clog2(num_frames) : 1;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with active-low sync and vblank-entry
// strobe; counters park at 0,0 while disabled.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic [COORD_W-1:0] h_count,
  output logic [COORD_W-1:0] v_count,
  output logic               active,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic               in_vblank,
  output logic               vblank_entry
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [COORD_W-1:0] h_q, h_d;
  logic [COORD_W-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_count      = h_q;
  assign v_count      = v_q;
  assign active       = enable && (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_n      = !(enable && (h_q >= HS_START) && (h_q < HS_END));
  assign vsync_n      = !(enable && (v_q >= VS_START) && (v_q < VS_END));
  assign in_vblank    = enable && (v_q >= V_ACT);
  assign vblank_entry = enable && (h_q == '0) && (v_q == V_ACT);

endmodule

// File: rtl/video_scanout_engine.sv
// Framebuffer scanout: register block, page flip at vblank and control pipeline
// aligned to framebuffer read latency. Scanline IRQ built with VIDEO_SCANLINE_IRQ_EN.
module video_scanout_engine
  import video_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int NUM_FRAMES  = 2,
  parameter int PIXEL_WIDTH = 8,
  parameter int FB_LATENCY  = 2,
  localparam int FRAME_W    = frame_sel_w(NUM_FRAMES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             bus_address,
  input  logic [31:0]            bus_write_data,
  input  logic                   bus_write_enable,
  input  logic                   bus_read_enable,
  output logic [31:0]            bus_data_fetched,
  output logic [FRAME_W-1:0]     fb_read_frame,
  output logic [COORD_W-1:0]     fb_read_x,
  output logic [COORD_W-1:0]     fb_read_y,
  input  logic [PIXEL_WIDTH-1:0] fb_read_data,
  output logic [PIXEL_WIDTH-1:0] pixel_data,
  output logic [COORD_W-1:0]     pixel_x_pos,
  output logic [COORD_W-1:0]     pixel_y_pos,
  output logic                   vga_horizontal_sync,
  output logic                   vga_vertical_sync,
  output logic                   vga_blank,
  output logic                   frame_irq
);

  logic               ctrl_enable_q, ctrl_enable_d;
  logic [2:0]         pending_frame_q, pending_frame_d;
  logic [2:0]         active_frame_q, active_frame_d;
  logic               vblank_pend_q, vblank_pend_d;
  logic               line_pend_q, line_pend_d;
  logic [COORD_W-1:0] line_cmp_q, line_cmp_d;
  logic [31:0]        frame_count_q, frame_count_d;
  logic [31:0]        bus_rdata_q, bus_rdata_d;

  pix_ctl_t [FB_LATENCY-1:0] pipe_q, pipe_d;
  pix_ctl_t                  pix_now;

  logic [COORD_W-1:0] h_count, v_count;
  logic               active, hsync_n, vsync_n, in_vblank, vblank_entry;
  logic               wr_ctrl, wr_status, pend_legal;
  logic               unused_bits;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clock        (clock),
    .reset        (reset),
    .enable       (ctrl_enable_q),
    .h_count      (h_count),
    .v_count      (v_count),
    .active       (active),
    .hsync_n      (hsync_n),
    .vsync_n      (vsync_n),
    .in_vblank    (in_vblank),
    .vblank_entry (vblank_entry)
  );

  assign wr_ctrl    = bus_write_enable && (reg_addr_e'(bus_address) == REG_CTRL);
  assign wr_status  = bus_write_enable && (reg_addr_e'(bus_address) == REG_STATUS);
  assign pend_legal = {29'd0, bus_write_data[CTRL_PEND_LSB +: 3]} < 32'(NUM_FRAMES);

`ifdef VIDEO_SCANLINE_IRQ_EN
  logic wr_line_cmp, line_hit;
  assign wr_line_cmp = bus_write_enable && (reg_addr_e'(bus_address) == REG_LINE_CMP);
  assign line_hit    = ctrl_enable_q && (h_count == '0) && (v_count == line_cmp_q);
`endif

  // Hardware set sequenced after W1C so a coincident set wins.
  always_comb begin
    ctrl_enable_d   = ctrl_enable_q;
    pending_frame_d = pending_frame_q;
    active_frame_d  = active_frame_q;
    vblank_pend_d   = vblank_pend_q;
    line_pend_d     = line_pend_q;
    line_cmp_d      = line_cmp_q;
    frame_count_d   = frame_count_q;

    if (wr_ctrl) begin
      ctrl_enable_d = bus_write_data[CTRL_ENABLE_BIT];
      if (pend_legal) pending_frame_d = bus_write_data[CTRL_PEND_LSB +: 3];
    end
    if (wr_status && bus_write_data[STAT_VBLANK_PEND_BIT]) vblank_pend_d = 1'b0;
    if (wr_status && bus_write_data[STAT_LINE_PEND_BIT])   line_pend_d   = 1'b0;

`ifdef VIDEO_SCANLINE_IRQ_EN
    if (wr_line_cmp) line_cmp_d = bus_write_data[COORD_W-1:0];
    if (line_hit)    line_pend_d = 1'b1;
`else
    line_cmp_d  = '0;
    line_pend_d = 1'b0;
`endif

    if (vblank_entry) begin
      active_frame_d = pending_frame_q;
      frame_count_d  = frame_count_q + 32'd1;
      vblank_pend_d  = 1'b1;
    end
  end

  always_comb begin
    bus_rdata_d = '0;
    if (bus_read_enable) begin
      case (reg_addr_e'(bus_address))
        REG_CTRL: begin
          bus_rdata_d[CTRL_ENABLE_BIT]      = ctrl_enable_q;
          bus_rdata_d[CTRL_PEND_LSB +: 3]   = pending_frame_q;
        end
        REG_STATUS: begin
          bus_rdata_d[STAT_ACTIVE_LSB +: 3] = active_frame_q;
          bus_rdata_d[STAT_IN_VBLANK_BIT]   = in_vblank;
          bus_rdata_d[STAT_VBLANK_PEND_BIT] = vblank_pend_q;
          bus_rdata_d[STAT_LINE_PEND_BIT]   = line_pend_q;
        end
        REG_LINE_CMP:    bus_rdata_d[COORD_W-1:0] = line_cmp_q;
        REG_FRAME_COUNT: bus_rdata_d = frame_count_q;
        default:         bus_rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    pix_now = '{hsync_n: hsync_n, vsync_n: vsync_n, blank_n: active,
                x: h_count, y: v_count};
    pipe_d  = pipe_q;
    if (!ctrl_enable_q) begin
      pipe_d = {FB_LATENCY{PIX_IDLE}};
    end else begin
      pipe_d[0] = pix_now;
      for (int unsigned i = 1; i < FB_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_enable_q   <= 1'b0;
      pending_frame_q <= '0;
      active_frame_q  <= '0;
      vblank_pend_q   <= 1'b0;
      line_pend_q     <= 1'b0;
      line_cmp_q      <= '0;
      frame_count_q   <= '0;
      bus_rdata_q     <= '0;
      pipe_q          <= {FB_LATENCY{PIX_IDLE}};
    end else begin
      ctrl_enable_q   <= ctrl_enable_d;
      pending_frame_q <= pending_frame_d;
      active_frame_q  <= active_frame_d;
      vblank_pend_q   <= vblank_pend_d;
      line_pend_q     <= line_pend_d;
      line_cmp_q      <= line_cmp_d;
      frame_count_q   <= frame_count_d;
      bus_rdata_q     <= bus_rdata_d;
      pipe_q          <= pipe_d;
    end
  end

  assign bus_data_fetched    = bus_rdata_q;
  assign fb_read_frame       = active_frame_q[FRAME_W-1:0];
  assign fb_read_x           = active ? h_count : '0;
  assign fb_read_y           = active ? v_count : '0;
  assign vga_horizontal_sync = pipe_q[FB_LATENCY-1].hsync_n;
  assign vga_vertical_sync   = pipe_q[FB_LATENCY-1].vsync_n;
  assign vga_blank           = pipe_q[FB_LATENCY-1].blank_n;
  assign pixel_x_pos         = pipe_q[FB_LATENCY-1].x;
  assign pixel_y_pos         = pipe_q[FB_LATENCY-1].y;
  assign pixel_data          = pipe_q[FB_LATENCY-1].blank_n ? fb_read_data : '0;
  assign frame_irq           = vblank_pend_q | line_pend_q;

  assign unused_bits = ^bus_write_data;

endmodule

// File: tb/tb_video_scanout_engine.sv
// Randomized bench for video_scanout_engine on a reduced raster, checked against
// a cycle-count reference model of raster position, registers and pixel alignment.
module tb_video_scanout_engine;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int VT = VA + VF + VS + VB;
  localparam int NF = 2, PW = 8, LAT = 3, FW = 1;
  localparam int MAXC = 16384;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    bus_address = '0;
  logic [31:0]   bus_write_data = '0;
  logic          bus_write_enable = 1'b0;
  logic          bus_read_enable = 1'b0;
  logic [31:0]   bus_data_fetched;
  logic [FW-1:0] fb_read_frame;
  logic [9:0]    fb_read_x, fb_read_y;
  logic [PW-1:0] fb_read_data;
  logic [PW-1:0] pixel_data;
  logic [9:0]    pixel_x_pos, pixel_y_pos;
  logic          vga_horizontal_sync, vga_vertical_sync, vga_blank, frame_irq;

  video_scanout_engine #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .NUM_FRAMES(NF), .PIXEL_WIDTH(PW), .FB_LATENCY(LAT)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .bus_address         (bus_address),
    .bus_write_data      (bus_write_data),
    .bus_write_enable    (bus_write_enable),
    .bus_read_enable     (bus_read_enable),
    .bus_data_fetched    (bus_data_fetched),
    .fb_read_frame       (fb_read_frame),
    .fb_read_x           (fb_read_x),
    .fb_read_y           (fb_read_y),
    .fb_read_data        (fb_read_data),
    .pixel_data          (pixel_data),
    .pixel_x_pos         (pixel_x_pos),
    .pixel_y_pos         (pixel_y_pos),
    .vga_horizontal_sync (vga_horizontal_sync),
    .vga_vertical_sync   (vga_vertical_sync),
    .vga_blank           (vga_blank),
    .frame_irq           (frame_irq)
  );

  always #5 clock = ~clock;

  function automatic logic [PW-1:0] pix_of(input int f, input int x, input int y);
    return PW'(x + 3 * y + 64 * f);
  endfunction

  // Framebuffer: content is a function of page and coordinates, returned LAT cycles later.
  logic [PW-1:0] fb_pipe [LAT];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) fb_pipe[i] <= '0;
    end else begin
      fb_pipe[0] <= pix_of(int'(fb_read_frame), int'(fb_read_x), int'(fb_read_y));
      for (int i = 1; i < LAT; i++) fb_pipe[i] <= fb_pipe[i-1];
    end
  end
  assign fb_read_data = fb_pipe[LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raster position is derived from cycles elapsed since enable.
  int          n_m = 0;
  bit          en_m = 1'b0;
  int          pend_m = 0, af_m = 0, lc_m = 0;
  logic [31:0] fc_m = '0, rd_m = '0;
  bit          vp_m = 1'b0, lp_m = 1'b0;

  bit val_h [MAXC];
  int h_h [MAXC];
  int v_h [MAXC];
  int f_h [MAXC];
  int k = 0;

  task automatic model_edge();
    int h, v, pend_n, af_n, lc_n;
    bit vb, ln, en_n, vp_n, lp_n;
    logic [31:0] rd_n, fc_n;
    h = n_m % HT;
    v = (n_m / HT) % VT;
    val_h[k] = en_m && !reset;
    h_h[k] = h;
    v_h[k] = v;
    f_h[k] = af_m;
    k++;
    if (reset) begin
      en_m = 1'b0; n_m = 0; pend_m = 0; af_m = 0; lc_m = 0;
      fc_m = '0; rd_m = '0; vp_m = 1'b0; lp_m = 1'b0;
      return;
    end
    vb = en_m && h == 0 && v == VA;
`ifdef VIDEO_SCANLINE_IRQ_EN
    ln = en_m && h == 0 && v == lc_m;
`else
    ln = 1'b0;
`endif
    rd_n = '0;
    if (bus_read_enable) begin
      case (bus_address)
        4'h0:    rd_n = {25'd0, 3'(pend_m), 3'd0, en_m};
        4'h4:    rd_n = {14'd0, lp_m, vp_m, 7'd0, (en_m && v >= VA), 5'd0, 3'(af_m)};
        4'h8:    rd_n = 32'(lc_m);
        4'hC:    rd_n = fc_m;
        default: rd_n = '0;
      endcase
    end
    en_n = en_m; pend_n = pend_m; af_n = af_m; fc_n = fc_m;
    vp_n = vp_m; lp_n = lp_m; lc_n = lc_m;
    if (bus_write_enable && bus_address == 4'h0) begin
      en_n = bus_write_data[0];
      if (int'(bus_write_data[6:4]) < NF) pend_n = int'(bus_write_data[6:4]);
    end
    if (bus_write_enable && bus_address == 4'h4) begin
      if (bus_write_data[16]) vp_n = 1'b0;
      if (bus_write_data[17]) lp_n = 1'b0;
    end
`ifdef VIDEO_SCANLINE_IRQ_EN
    if (bus_write_enable && bus_address == 4'h8) lc_n = int'(bus_write_data[9:0]);
`endif
    if (ln) lp_n = 1'b1;
    if (vb) begin
      af_n = pend_m;
      fc_n = fc_m + 32'd1;
      vp_n = 1'b1;
    end
    n_m = en_m ? n_m + 1 : 0;
    en_m = en_n; pend_m = pend_n; af_m = af_n; fc_m = fc_n;
    vp_m = vp_n; lp_m = lp_n; lc_m = lc_n; rd_m = rd_n;
  endtask

  task automatic check_all();
    bit ok, bl, act;
    int j, hh, vv, h, v;
    ok = (k >= LAT);
    if (ok) for (int i = 1; i <= LAT; i++) if (!val_h[k-i]) ok = 1'b0;
    if (ok) begin
      j = k - LAT;
      hh = h_h[j];
      vv = v_h[j];
      bl = hh < HA && vv < VA;
      expect_eq("blank", 32'(vga_blank), 32'(bl));
      expect_eq("hsync", 32'(vga_horizontal_sync), 32'(!(hh >= HA + HF && hh < HA + HF + HS)));
      expect_eq("vsync", 32'(vga_vertical_sync), 32'(!(vv >= VA + VF && vv < VA + VF + VS)));
      expect_eq("pix_x", 32'(pixel_x_pos), 32'(hh));
      expect_eq("pix_y", 32'(pixel_y_pos), 32'(vv));
      expect_eq("pixel", 32'(pixel_data), bl ? 32'(pix_of(f_h[j], hh, vv)) : 32'd0);
    end else begin
      expect_eq("idle_blank", 32'(vga_blank), 32'd0);
      expect_eq("idle_hsync", 32'(vga_horizontal_sync), 32'd1);
      expect_eq("idle_vsync", 32'(vga_vertical_sync), 32'd1);
      expect_eq("idle_pix_x", 32'(pixel_x_pos), 32'd0);
      expect_eq("idle_pix_y", 32'(pixel_y_pos), 32'd0);
      expect_eq("idle_pixel", 32'(pixel_data), 32'd0);
    end
    h = n_m % HT;
    v = (n_m / HT) % VT;
    act = en_m && h < HA && v < VA;
    expect_eq("fb_x", 32'(fb_read_x), act ? 32'(h) : 32'd0);
    expect_eq("fb_y", 32'(fb_read_y), act ? 32'(v) : 32'd0);
    expect_eq("fb_frame", 32'(fb_read_frame), 32'(af_m));
    expect_eq("irq", 32'(frame_irq), 32'(vp_m | lp_m));
    expect_eq("rdata", bus_data_fetched, rd_m);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic bus_idle();
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_address = a;
    bus_write_data = d;
    bus_write_enable = 1'b1;
    bus_read_enable = 1'b0;
    cycle();
    bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    bus_address = a;
    bus_write_enable = 1'b0;
    bus_read_enable = 1'b1;
    cycle();
    bus_idle();
    expect_eq(tag, bus_data_fetched, exp);
  endtask

  task automatic run_rand(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus_write_enable = 1'b0;
      bus_read_enable  = ($urandom_range(3) == 0);
      bus_address      = 4'($urandom_range(3) * 4);
      if ($urandom_range(15) == 0) begin
        bus_write_enable = 1'b1;
        case (bus_address)
          4'h0:    bus_write_data = {25'd0, 3'($urandom_range(7)), 3'd0, 1'b1};
          4'h4:    bus_write_data = {14'd0, 2'($urandom_range(3)), 16'd0};
          4'h8:    bus_write_data = 32'($urandom_range(VT - 1));
          default: bus_write_data = $urandom();
        endcase
      end
      cycle();
    end
    bus_idle();
  endtask

  // Leaves the bench in the period whose edge performs vblank entry.
  task automatic run_until_vb();
    bit found;
    found = 1'b0;
    for (int c = 0; c < HT * VT + 4 && !found; c++) begin
      if (en_m && n_m % HT == 0 && (n_m / HT) % VT == VA) found = 1'b1;
      else cycle();
    end
    expect_eq("vb_wait", 32'(found), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    bus_idle();
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    expect_eq("rst_hsync", 32'(vga_horizontal_sync), 32'd1);
    expect_eq("rst_vsync", 32'(vga_vertical_sync), 32'd1);
    expect_eq("rst_blank", 32'(vga_blank), 32'd0);
    expect_eq("rst_pixel", 32'(pixel_data), 32'd0);
    expect_eq("rst_irq", 32'(frame_irq), 32'd0);
    expect_eq("rst_bus", bus_data_fetched, 32'd0);
    bus_read(4'hC, 32'd0, "rst_fcount");

    bus_write(4'h0, 32'h1);
    c = 0;
    while (vga_horizontal_sync === 1'b1 && c < 4 * HT) begin cycle(); c++; end
    expect_eq("hs_start", 32'(c), 32'(HA + HF + LAT));
    c = 0;
    while (vga_horizontal_sync === 1'b0 && c < 4 * HT) begin cycle(); c++; end
    expect_eq("hs_len", 32'(c), 32'(HS));

    run_rand(HT * VT * 2);

    bus_write(4'h0, 32'h01);
    run_until_vb();
    cycle();
    bus_write(4'h0, 32'h11);
    run_until_vb();
    expect_eq("frame_pre_vb", 32'(fb_read_frame), 32'd0);
    cycle();
    expect_eq("frame_post_vb", 32'(fb_read_frame), 32'd1);

    bus_write(4'h0, 32'h51);
    bus_read(4'h0, 32'h11, "ctrl_bad_pend");
    run_until_vb();
    cycle();
    expect_eq("frame_kept", 32'(fb_read_frame), 32'd1);

    bus_write(4'h4, 32'h30000);
    run_until_vb();
    bus_write(4'h4, 32'h10000);
    expect_eq("irq_set_wins", 32'(frame_irq), 32'd1);
    bus_write(4'h4, 32'h30000);
    expect_eq("irq_w1c", 32'(frame_irq), 32'd0);

    bus_write(4'h8, 32'd100);
`ifdef VIDEO_SCANLINE_IRQ_EN
    bus_read(4'h8, 32'd100, "line_cmp_rd");
`else
    bus_read(4'h8, 32'd0, "line_cmp_rd");
`endif

    run_rand(HT * 5);
    bus_write(4'h0, 32'h10);
    repeat (LAT + 2) cycle();
    expect_eq("dis_blank", 32'(vga_blank), 32'd0);
    expect_eq("dis_hsync", 32'(vga_horizontal_sync), 32'd1);
    expect_eq("dis_fb_x", 32'(fb_read_x), 32'd0);
    bus_write(4'h0, 32'h11);
    run_rand(HT * VT / 2 + 7);

    reset = 1'b1;
    cycle();
    reset = 1'b0;
    expect_eq("mid_rst_blank", 32'(vga_blank), 32'd0);
    expect_eq("mid_rst_irq", 32'(frame_irq), 32'd0);
    bus_read(4'h0, 32'd0, "mid_rst_ctrl");
    bus_write(4'h0, 32'h1);
    run_rand(HT * VT + 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_scanout_engine.md
VIDEO_SCANOUT_ENGINE -- requirements
Module: video_scanout_engine

Interface
REQ-001 Parameters, one per line (name, default, meaning); H_ACTIVE/H_FRONT/H_SYNC/H_BACK = 640/16/96/48, horizontal timing in pixels.
REQ-002 V_ACTIVE/V_FRONT/V_SYNC/V_BACK = 480/10/2/33, vertical timing in lines.
REQ-003 NUM_FRAMES, 2, framebuffer pages (1..8); PIXEL_WIDTH, 8, pixel bits; FB_LATENCY, 2, framebuffer read latency in cycles (1..4).
REQ-004 Ports, one per line (name direction width meaning); clock input 1, pixel clock; reset input 1, synchronous active-high reset.
REQ-005 bus_address input 4 (register byte offset); bus_write_data input 32; bus_write_enable input 1; bus_read_enable input 1; bus_data_fetched output 32.
REQ-006 fb_read_frame output clog2(NUM_FRAMES); fb_read_x output 10; fb_read_y output 10; fb_read_data input PIXEL_WIDTH (valid FB_LATENCY cycles after address).
REQ-007 pixel_data output PIXEL_WIDTH; pixel_x_pos output 10; pixel_y_pos output 10; vga_horizontal_sync, vga_vertical_sync, vga_blank output 1 each (active-low); frame_irq output 1.

Function
REQ-008 Registers: 0x0 CTRL (bit0 enable, bits[6:4] pending_frame); 0x4 STATUS (bits[2:0] active_frame RO, bit8 in_vblank RO, bit16 vblank_pend W1C, bit17 line_pend W1C); 0x8 LINE_CMP (bits[9:0]); 0xC FRAME_COUNT (RO).
REQ-009 bus_data_fetched SHALL be registered: valid one cycle after bus_read_enable, 0 otherwise; unused bits read 0.
REQ-010 CTRL write with pending_frame >= NUM_FRAMES SHALL keep old pending_frame; enable bit still updates.
REQ-011 Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1) SHALL advance every cycle while enabled; h wraps to 0 with v increment; v wraps to 0 after V_TOTAL-1.
REQ-012 Active region h<H_ACTIVE and v<V_ACTIVE; fb_read_x/y = h/v in active region, 0 otherwise.
REQ-013 hsync low for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC); vsync low likewise on v.
REQ-014 Sync, blank, pixel_x_pos, pixel_y_pos SHALL be delayed FB_LATENCY cycles via shift pipeline so they align with fb_read_data.
REQ-015 pixel_data = fb_read_data when aligned blank is high, 0 when blanked.
REQ-016 At h=0, v=V_ACTIVE (vblank entry): active_frame <= pending_frame, FRAME_COUNT += 1 (wraps 2^32-1 -> 0), vblank_pend <= 1.
REQ-017 Pending-frame write in the same cycle as vblank entry SHALL take effect at the next vblank entry.
REQ-018 W1C and hardware set in the same cycle: set wins.
REQ-019 frame_irq = OR of enabled pending bits, combinational from registered flags.
REQ-020 enable cleared: h,v held at 0, syncs high, blank low, pixel_data 0, pipeline flushed to blank; enable set restarts at h=0,v=0.

Reset
REQ-021 Reset SHALL zero CTRL, LINE_CMP, FRAME_COUNT, active_frame, pending bits, h, v, pipeline; outputs after reset: syncs 1, blank 0, pixel_data 0, frame_irq 0, bus_data_fetched 0.
REQ-022 Reset mid-frame SHALL take effect next edge regardless of pipeline contents.

Configuration
REQ-023 Macro VIDEO_SCANLINE_IRQ_EN: defined -> at h=0, v=LINE_CMP, line_pend <= 1 and contributes to frame_irq; undefined -> line_pend, LINE_CMP read 0, writes ignored, frame_irq = vblank_pend only.

Structure
REQ-024 Register offsets, bit positions and default timing constants SHALL live in shared package video_pkg.
REQ-025 Counter/sync generation SHALL be sub-module video_timing_gen; registers and alignment pipeline in top.

Verification
REQ-026 Reset, enable=1, NUM_FRAMES=2: first hsync low at cycle 656 for 96 cycles; vsync low for lines 490-491.
REQ-027 FB_LATENCY=3, fb_read_data = fb_read_x[7:0]: pixel_data equals pixel_x_pos[7:0] every active pixel, 0 in blanking.
REQ-028 Write CTRL pending_frame=1 mid-frame: fb_read_frame stays 0 until h=0,v=480, then 1; FRAME_COUNT increments by 1.
REQ-029 Write pending_frame=5 (NUM_FRAMES=2): pending_frame unchanged, active_frame unchanged at vblank.
REQ-030 W1C bit16 on vblank-entry cycle: vblank_pend stays 1, frame_irq stays 1; W1C next cycle clears both.
REQ-031 With VIDEO_SCANLINE_IRQ_EN, LINE_CMP=100: line_pend rises at h=0,v=100; without macro, LINE_CMP reads 0 after write.
